// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and default constants for the instruction-fetch stage.
// Rev    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned PC_WIDTH_DEF       = 12;
    localparam int unsigned INST_WIDTH_DEF     = 19;
    localparam int unsigned RESET_PC_DEF       = 0;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [INST_WIDTH_DEF-1:0] NOP = '0;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_if
// Brief  : Instruction-memory req/ack handshake bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned INST_WIDTH = INST_WIDTH_DEF
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr, output imem_ack, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module : pc_reg
// Brief  : Program counter with sync reset, load enable and +1/branch mux.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                ld,
    input  wire logic                sel_branch,
    input  wire logic [PC_WIDTH-1:0] branch_target,
    output logic      [PC_WIDTH-1:0] pc,
    output logic      [PC_WIDTH-1:0] pc_inc
);
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;

    // Increment wraps modulo 2^PC_WIDTH by construction.
    assign pc_inc   = r_pc + 1'b1;
    assign w_pc_nxt = sel_branch ? branch_target : pc_inc;
    assign pc       = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= PC_WIDTH'(RESET_PC);
        end else if (ld) begin
            r_pc <= w_pc_nxt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : IF stage - PC ownership, imem req/ack fetch, IF/ID buffer drive.
//          Optional request timeout enabled by defining FETCH_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH       = PC_WIDTH_DEF,
    parameter int unsigned INST_WIDTH     = INST_WIDTH_DEF,
    parameter int unsigned RESET_PC       = RESET_PC_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  stall,
    input  wire logic                  branch_taken,
    input  wire logic [PC_WIDTH-1:0]   branch_target,
    fetch_unit_if.master               imem,
    output logic                       if_ld,
    output logic      [INST_WIDTH-1:0] if_inst,
    output logic      [PC_WIDTH-1:0]   if_pc_next,
    output logic                       if_valid,
    output logic                       fetch_err
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [INST_WIDTH-1:0] r_inst;
    logic [PC_WIDTH-1:0]   r_pc_next;
    logic [PC_WIDTH-1:0]   w_pc;
    logic [PC_WIDTH-1:0]   w_pc_inc;
    logic                  w_pc_ld;
    logic                  w_capture;
    logic                  w_timeout;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .ld            (w_pc_ld),
        .sel_branch    (branch_taken),
        .branch_target (branch_target),
        .pc            (w_pc),
        .pc_inc        (w_pc_inc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait;
    logic              r_err;

    assign w_timeout = (r_state == REQ) && !branch_taken && !imem.imem_ack
                       && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err = r_err;

    // Counter only runs while waiting in REQ; any exit or redirect clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state == REQ) && !branch_taken && !imem.imem_ack && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_pc_ld     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            REQ: begin
                if (branch_taken) begin
                    w_pc_ld = 1'b1;
                end else if (imem.imem_ack || w_timeout) begin
                    w_pc_ld     = 1'b1;
                    w_capture   = imem.imem_ack;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_pc_ld     = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= REQ;
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_pc_next <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_inst    <= imem.imem_rdata;
                r_pc_next <= w_pc_inc;
            end else if (w_timeout) begin
                r_inst    <= INST_WIDTH'(NOP);
                r_pc_next <= w_pc_inc;
            end
        end
    end

    assign imem.imem_req  = (r_state == REQ) && !rst;
    assign imem.imem_addr = w_pc;
    assign if_ld          = (r_state == HOLD) && !stall && !branch_taken && !rst;
    assign if_inst        = r_inst;
    assign if_pc_next     = r_pc_next;
    assign if_valid       = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit with load scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned PW = 12;
    localparam int unsigned IW = 19;

    logic          clk           = 1'b0;
    logic          rst           = 1'b1;
    logic          stall         = 1'b0;
    logic          branch_taken  = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic          if_ld;
    logic          if_valid;
    logic          fetch_err;
    logic [IW-1:0] if_inst;
    logic [PW-1:0] if_pc_next;

    fetch_unit_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) imem_if ();

    fetch_unit #(
        .PC_WIDTH       (PW),
        .INST_WIDTH     (IW),
        .RESET_PC       (0),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_if),
        .if_ld         (if_ld),
        .if_inst       (if_inst),
        .if_pc_next    (if_pc_next),
        .if_valid      (if_valid),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [PW-1:0] pcn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [IW-1:0] inst, input logic [PW-1:0] pcn);
        exp_t e;
        e.inst = inst;
        e.pcn  = pcn;
        sb.push_back(e);
    endtask

    // Every IF/ID load must match the oldest outstanding expected fetch.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (if_ld === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_load: observed=load expected=no_load");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_inst", 32'(if_inst), 32'(e.inst));
                chk("sb_pc_next", 32'(if_pc_next), 32'(e.pcn));
            end
        end
    end

    initial begin
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = '0;

        // Reset
        step();
        step();
        #1;
        chk("rst_req", 32'(imem_if.imem_req), 0);
        chk("rst_ld", 32'(if_ld), 0);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_inst", 32'(if_inst), 0);
        chk("rst_pcn", 32'(if_pc_next), 0);
        chk("rst_err", 32'(fetch_err), 0);
        rst = 1'b0;
        #1;
        chk("req0_req", 32'(imem_if.imem_req), 1);
        chk("req0_addr", 32'(imem_if.imem_addr), 0);

        // Basic 1-cycle ack
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h1234;
        push(19'h1234, 12'h001);
        step();
        imem_if.imem_ack = 1'b0;
        #1;
        chk("hold_ld", 32'(if_ld), 1);
        chk("hold_inst", 32'(if_inst), 32'h1234);
        chk("hold_pcn", 32'(if_pc_next), 1);
        chk("hold_valid", 32'(if_valid), 1);
        chk("hold_req", 32'(imem_if.imem_req), 0);
        step();
        #1;
        chk("req1_addr", 32'(imem_if.imem_addr), 1);

        // Stall for three cycles
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h2AAAA;
        stall              = 1'b1;
        push(19'h2AAAA, 12'h002);
        for (int i = 0; i < 3; i++) begin
            step();
            imem_if.imem_ack = 1'b0;
            #1;
            chk("stall_valid", 32'(if_valid), 1);
            chk("stall_ld", 32'(if_ld), 0);
            chk("stall_inst", 32'(if_inst), 32'h2AAAA);
            chk("stall_req", 32'(imem_if.imem_req), 0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ld", 32'(if_ld), 1);
        step();
        #1;
        chk("req2_addr", 32'(imem_if.imem_addr), 2);

        // Branch in HOLD flushes the buffer
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h00555;
        step();
        imem_if.imem_ack = 1'b0;
        branch_taken     = 1'b1;
        branch_target    = 12'h040;
        #1;
        chk("flush_ld", 32'(if_ld), 0);
        chk("flush_valid_pre", 32'(if_valid), 1);
        step();
        branch_taken = 1'b0;
        #1;
        chk("flush_valid", 32'(if_valid), 0);
        chk("flush_req", 32'(imem_if.imem_req), 1);
        chk("flush_addr", 32'(imem_if.imem_addr), 32'h040);

        // Branch together with ack in REQ discards the data
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h07777;
        branch_taken       = 1'b1;
        branch_target      = 12'h040;
        step();
        #1;
        chk("brack_req", 32'(imem_if.imem_req), 1);
        chk("brack_valid", 32'(if_valid), 0);
        chk("brack_inst", 32'(if_inst), 32'h00555);
        chk("brack_addr", 32'(imem_if.imem_addr), 32'h040);
        branch_target = 12'h123;
        step();
        imem_if.imem_ack = 1'b0;
        branch_taken     = 1'b0;
        #1;
        chk("brack2_addr", 32'(imem_if.imem_addr), 32'h123);
        chk("brack2_req", 32'(imem_if.imem_req), 1);

        // PC wrap at all-ones
        branch_taken  = 1'b1;
        branch_target = 12'hFFF;
        step();
        branch_taken = 1'b0;
        #1;
        chk("wrap_addr", 32'(imem_if.imem_addr), 32'hFFF);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h04321;
        push(19'h04321, 12'h000);
        step();
        imem_if.imem_ack = 1'b0;
        #1;
        chk("wrap_ld", 32'(if_ld), 1);
        chk("wrap_pcn", 32'(if_pc_next), 0);
        chk("wrap_inst", 32'(if_inst), 32'h04321);
        step();
        #1;
        chk("wrap_next_addr", 32'(imem_if.imem_addr), 0);

        // Reset while waiting for ack
        branch_taken  = 1'b1;
        branch_target = 12'h0AB;
        step();
        branch_taken = 1'b0;
        #1;
        chk("pre_rst_addr", 32'(imem_if.imem_addr), 32'h0AB);
        rst                = 1'b1;
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 19'h01111;
        #1;
        chk("midrst_req", 32'(imem_if.imem_req), 0);
        chk("midrst_ld", 32'(if_ld), 0);
        step();
        rst              = 1'b0;
        imem_if.imem_ack = 1'b0;
        #1;
        chk("postrst_req", 32'(imem_if.imem_req), 1);
        chk("postrst_addr", 32'(imem_if.imem_addr), 0);
        chk("postrst_valid", 32'(if_valid), 0);
        chk("postrst_inst", 32'(if_inst), 0);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            step();
            #1;
            chk("to_wait_err", 32'(fetch_err), 0);
            chk("to_wait_req", 32'(imem_if.imem_req), 1);
        end
        push(IW'(0), 12'h001);
        step();
        #1;
        chk("to_err", 32'(fetch_err), 1);
        chk("to_inst", 32'(if_inst), 0);
        chk("to_pcn", 32'(if_pc_next), 1);
        chk("to_valid", 32'(if_valid), 1);
        chk("to_ld", 32'(if_ld), 1);
        step();
        #1;
        chk("to_next_addr", 32'(imem_if.imem_addr), 1);
        chk("to_sticky", 32'(fetch_err), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("to_rst_clear", 32'(fetch_err), 0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
        end
        #1;
        chk("noto_req", 32'(imem_if.imem_req), 1);
        chk("noto_addr", 32'(imem_if.imem_addr), 0);
        chk("noto_valid", 32'(if_valid), 0);
        chk("noto_err", 32'(fetch_err), 0);
`endif

        step();
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
